i2c_xfer_ctrl: RTL and testbench
================================

// Module: i2c_xfer_ctrl
// PURPOSE
//  Command sequencer driving i2c_master_top through its Wishbone slave port.
//  Accepts one register-level I2C command (write or read of one byte at a slave register).
//  Expands it into PRER/CTR/TXR/CR/SR/RXR bus cycles: programs the prescaler, runs START/WR/RD/STOP, polls TIP.
//  Returns the read data plus a status code. Sits between firmware/bench command logic and the core.
// PARAMETERS
//  PRESCALE  16'd4   value written to PRERlo/PRERhi at init (SCL = clk/(5*(PRESCALE+1)))
//  TO_CYCLES 16'd4096 SR poll timeout in clocks (used only with I2C_XFER_TIMEOUT_EN)
// PORTS
//  wb_clk_i    in  1  single clock, all logic rising-edge
//  arst_i      in  1  asynchronous active-high reset
//  cmd_valid   in  1  command request
//  cmd_ready   out 1  high only in IDLE; command accepted on cmd_valid&cmd_ready
//  cmd_rw      in  1  0=write, 1=read
//  cmd_addr    in  7  7-bit slave address
//  cmd_reg     in  8  slave register index
//  cmd_wdata   in  8  write byte (ignored for reads)
//  rsp_valid   out 1  one-cycle pulse at command completion
//  rsp_rdata   out 8  RXR byte for reads, 8'h00 for writes/errors; held until next rsp
//  rsp_err     out 2  00 ok, 01 slave NACK, 10 arbitration lost, 11 timeout
//  busy_o      out 1  high from accept (or reset init) until rsp_valid
//  m_wb_adr_o  out 3  core register address (0 PRERlo,1 PRERhi,2 CTR,3 TXR/RXR,4 CR/SR)
//  m_wb_dat_o  out 8  write data
//  m_wb_dat_i  in  8  read data
//  m_wb_we_o   out 1  write enable
//  m_wb_stb_o  out 1  strobe
//  m_wb_cyc_o  out 1  cycle
//  m_wb_ack_i  in  1  core acknowledge
// BEHAVIOUR
//  Reset: all outputs 0 except busy_o=1; rsp_rdata=8'h00; state INIT_PRL.
//  Bus cycle: assert cyc/stb/we/adr/dat together, hold stable until ack; drop cyc/stb the cycle after ack; min 1 idle cycle between accesses.
//  Init: write PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=8'h80 (EN, no IEN); then IDLE, busy_o=0.
//  Byte step BYTE(t,c): write TXR=t; write CR=c; POLL = read SR until SR[1](TIP)=0.
//  Write cmd: BYTE({addr,0},8'h90) BYTE(reg,8'h10) BYTE(wdata,8'h50).
//  Read cmd: BYTE({addr,0},8'h90) BYTE(reg,8'h10) BYTE({addr,1},8'h90); then write CR=8'h68 (RD|NACK|STO); POLL; read RXR -> rsp_rdata.
//  After every POLL following a WR: SR[5](AL)=1 -> err 10, go RESP directly (no STOP);
//   else SR[7](RxACK)=1 -> write CR=8'h40 (STO), POLL, err 01, RESP.
//  AL checked before RxACK. The final read-byte POLL ignores RxACK (master NACK is expected).
//  States: INIT_PRL,INIT_PRH,INIT_CTR,IDLE,WR_TXR,WR_CR,POLL,CHK,RD_CMD,RD_RXR,STOP_CR,STOP_POLL,RESP.
//   A 2-bit step counter selects the byte/CR value; POLL re-issues SR reads back-to-back.
//  RESP: rsp_valid=1 for one cycle, busy_o=0 next cycle, return to IDLE.
//  The next command may be accepted the cycle after rsp_valid.
//  cmd_* fields are captured at accept; later changes are ignored.
//  cmd_valid during INIT or busy: not accepted, no state change.
//  arst_i mid-transfer: bus cycle abandoned (cyc/stb low asynchronously), re-run init; no rsp emitted.
//  Spurious m_wb_ack_i outside an active cycle is ignored.
// CONFIGURATION
//  I2C_XFER_TIMEOUT_EN defined:
//   16-bit counter clears on POLL/STOP_POLL entry, counts each clock in them.
//   Reaching TO_CYCLES -> write CR=8'h40, go RESP with err 11 (no further polling).
//  Not defined: no counter; POLL waits indefinitely; err 11 never produced.
// TESTING
//  Reset release -> PRERlo=04, PRERhi=00, CTR=80 written in order; busy_o falls; cmd_ready=1.
//  Write addr 7'h02 reg 8'h01 data 8'hA5, slave ACKs -> TXR 04/01/A5, CR 90/10/50; rsp_err=00; slave reg1=A5.
//  Read addr 7'h02 reg 8'h01 after above -> TXR 04,01,05; CR 90,10,90,68; rsp_rdata=A5, rsp_err=00.
//  Write to absent addr 7'h10 -> first POLL sees RxACK=1; CR=40 issued; rsp_err=01, rsp_rdata=00.
//  arst_i pulsed mid-read (during 2nd POLL) -> stb/cyc low at once; no rsp_valid; init sequence repeats.
//  With I2C_XFER_TIMEOUT_EN, TO_CYCLES=64, SR forced TIP=1 -> CR=40 write, rsp_err=11 within 64+bus cycles.

Source files
------------

// File: rtl/i2c_xfer_ctrl.sv
// Register-level I2C command sequencer driving i2c_master_top over Wishbone.
// Optional SR-poll timeout enabled by defining I2C_XFER_TIMEOUT_EN.
module i2c_xfer_ctrl #(
  parameter logic [15:0] PRESCALE  = 16'd4,
  parameter logic [15:0] TO_CYCLES = 16'd4096
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy_o,
  output logic [2:0] m_wb_adr_o,
  output logic [7:0] m_wb_dat_o,
  input  logic [7:0] m_wb_dat_i,
  output logic       m_wb_we_o,
  output logic       m_wb_stb_o,
  output logic       m_wb_cyc_o,
  input  logic       m_wb_ack_i
);

  typedef enum logic [3:0] {
    INIT_PRL, INIT_PRH, INIT_CTR, IDLE,
    WR_TXR, WR_CR, POLL, CHK, RD_CMD,
    RD_RXR, STOP_CR, STOP_POLL, RESP
  } state_t;

  state_t     state, nxt;
  logic       cyc;
  logic       done;
  logic       to_hit;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] reg_q, wdata_q, sr_q;
  logic [1:0] step, step_nxt;
  logic [1:0] err, err_nxt;
  logic [7:0] txb, crb;
  logic       go, go_we;
  logic [2:0] go_adr;
  logic [7:0] go_dat;

  assign done       = cyc & m_wb_ack_i;
  assign m_wb_cyc_o = cyc;
  assign m_wb_stb_o = cyc;
  assign cmd_ready  = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_err    = err;

`ifdef I2C_XFER_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        polling, entering;

  assign polling  = (state == POLL) || (state == STOP_POLL);
  assign entering = ((nxt == POLL) || (nxt == STOP_POLL)) && (nxt != state);
  assign to_hit   = (to_cnt >= TO_CYCLES);

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i)                  to_cnt <= '0;
    else if (entering)           to_cnt <= '0;
    else if (polling && !to_hit) to_cnt <= to_cnt + 16'd1;
  end
`else
  logic unused_to;
  assign unused_to = ^TO_CYCLES;
  assign to_hit    = 1'b0;
`endif

  // step selects which of the three address/register/data bytes is sent
  always_comb begin
    txb = 8'h00;
    crb = 8'h00;
    unique case (step)
      2'd0: begin txb = {addr_q, 1'b0}; crb = 8'h90; end
      2'd1: begin txb = reg_q;          crb = 8'h10; end
      default: begin
        txb = rw_q ? {addr_q, 1'b1} : wdata_q;
        crb = rw_q ? 8'h90 : 8'h50;
      end
    endcase
  end

  always_comb begin
    go     = 1'b1;
    go_we  = 1'b1;
    go_adr = 3'd0;
    go_dat = 8'h00;
    unique case (state)
      INIT_PRL: go_dat = PRESCALE[7:0];
      INIT_PRH: begin go_adr = 3'd1; go_dat = PRESCALE[15:8]; end
      INIT_CTR: begin go_adr = 3'd2; go_dat = 8'h80; end
      WR_TXR:   begin go_adr = 3'd3; go_dat = txb; end
      WR_CR:    begin go_adr = 3'd4; go_dat = crb; end
      RD_CMD:   begin go_adr = 3'd4; go_dat = 8'h68; end
      STOP_CR:  begin go_adr = 3'd4; go_dat = 8'h40; end
      RD_RXR:   begin go_adr = 3'd3; go_we = 1'b0; end
      POLL, STOP_POLL: begin
        go_adr = 3'd4;
        go_we  = 1'b0;
        go     = !to_hit;
      end
      default:  go = 1'b0;
    endcase
  end

  always_comb begin
    nxt      = state;
    step_nxt = step;
    err_nxt  = err;
    unique case (state)
      INIT_PRL: if (done) nxt = INIT_PRH;
      INIT_PRH: if (done) nxt = INIT_CTR;
      INIT_CTR: if (done) nxt = IDLE;
      IDLE: if (cmd_valid) begin
        nxt      = WR_TXR;
        step_nxt = 2'd0;
        err_nxt  = 2'b00;
      end
      WR_TXR: if (done) nxt = WR_CR;
      WR_CR:  if (done) nxt = POLL;
      POLL: begin
        if (done) begin
          if (!m_wb_dat_i[1]) nxt = CHK;
        end else if (!cyc && to_hit) begin
          nxt     = STOP_CR;
          err_nxt = 2'b11;
        end
      end
      // step 3 marks the final read byte, whose NACK is expected
      CHK: begin
        if (step == 2'd3) nxt = RD_RXR;
        else if (sr_q[5]) begin
          nxt     = RESP;
          err_nxt = 2'b10;
        end else if (sr_q[7]) begin
          nxt     = STOP_CR;
          err_nxt = 2'b01;
        end else if (step == 2'd2) begin
          nxt = rw_q ? RD_CMD : RESP;
        end else begin
          nxt      = WR_TXR;
          step_nxt = step + 2'd1;
        end
      end
      RD_CMD: if (done) begin
        nxt      = POLL;
        step_nxt = 2'd3;
      end
      RD_RXR:  if (done) nxt = RESP;
      STOP_CR: if (done) nxt = (err == 2'b11) ? RESP : STOP_POLL;
      STOP_POLL: begin
        if (done) begin
          if (!m_wb_dat_i[1]) nxt = RESP;
        end else if (!cyc && to_hit) begin
          nxt     = STOP_CR;
          err_nxt = 2'b11;
        end
      end
      RESP:    nxt = IDLE;
      default: nxt = INIT_PRL;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= INIT_PRL;
      step      <= 2'd0;
      err       <= 2'b00;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      sr_q      <= '0;
      rsp_rdata <= 8'h00;
    end else begin
      state <= nxt;
      step  <= step_nxt;
      err   <= err_nxt;
      if (state == IDLE && cmd_valid) begin
        rw_q    <= cmd_rw;
        addr_q  <= cmd_addr;
        reg_q   <= cmd_reg;
        wdata_q <= cmd_wdata;
      end
      if (state == POLL && done) sr_q <= m_wb_dat_i;
      if (nxt == RESP && state != RESP)
        rsp_rdata <= (state == RD_RXR) ? m_wb_dat_i : 8'h00;
    end
  end

  // one idle cycle always follows an ack because cyc drops before restart
  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      cyc        <= 1'b0;
      m_wb_adr_o <= 3'd0;
      m_wb_dat_o <= 8'h00;
      m_wb_we_o  <= 1'b0;
    end else if (done) begin
      cyc <= 1'b0;
    end else if (!cyc && go) begin
      cyc        <= 1'b1;
      m_wb_adr_o <= go_adr;
      m_wb_dat_o <= go_dat;
      m_wb_we_o  <= go_we;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Directed bench for i2c_xfer_ctrl with a behavioural i2c_master_top model.
// Timeout case runs only when I2C_XFER_TIMEOUT_EN is defined.
module tb_i2c_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic [2:0] adr;
  logic [7:0] dato, dati;
  logic       we, stb, cyc, ack;

  always #5 clk = ~clk;

  i2c_xfer_ctrl #(.PRESCALE(16'd4), .TO_CYCLES(16'd64)) dut (
    .wb_clk_i(clk), .arst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy_o(busy), .m_wb_adr_o(adr), .m_wb_dat_o(dato),
    .m_wb_dat_i(dati), .m_wb_we_o(we), .m_wb_stb_o(stb),
    .m_wb_cyc_o(cyc), .m_wb_ack_i(ack)
  );

  // core model: slave 7'h02 present, TIP busy for a few SR reads
  logic        ack_r = 1'b0;
  logic        spur = 1'b0;
  logic        force_tip = 1'b0;
  logic        force_al = 1'b0;
  logic [7:0]  txr = '0, rxr = '0, ptr = '0;
  logic        rxack = 1'b0;
  int          tip_cnt = 0;
  int          byte_idx = 0;
  logic [7:0]  mem [256];
  logic [10:0] wlog [256];
  int          wcnt = 0;
  int          rsp_cnt = 0;
  int          proto_err = 0;
  logic [7:0]  sr_m;

  assign ack  = ack_r | spur;
  assign sr_m = {rxack, 1'b0, force_al, 3'b000,
                 force_tip || (tip_cnt != 0), 1'b0};
  assign dati = (adr == 3'd4) ? sr_m : (adr == 3'd3) ? rxr : 8'h00;

  always @(posedge clk) begin
    ack_r <= cyc & stb & !ack_r;
    if (cyc && stb && ack_r) begin
      if (we) begin
        wlog[wcnt[7:0]] <= {adr, dato};
        wcnt <= wcnt + 1;
        if (adr == 3'd3) txr <= dato;
        else if (adr == 3'd4) begin
          if (dato[7]) begin
            rxack <= (txr[7:1] != 7'h02);
            byte_idx <= 0;
            tip_cnt <= 2;
          end else if (dato[4]) begin
            if (byte_idx == 0) ptr <= txr;
            else mem[ptr] <= txr;
            byte_idx <= byte_idx + 1;
            rxack <= 1'b0;
            tip_cnt <= 2;
          end else if (dato[5]) begin
            rxr <= mem[ptr];
            tip_cnt <= 2;
          end else if (dato[6]) begin
            tip_cnt <= 1;
          end
        end
      end else if (adr == 3'd4 && tip_cnt > 0) begin
        tip_cnt <= tip_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  // Wishbone protocol watcher
  logic        p_cyc = 1'b0, p_ack = 1'b0;
  logic [11:0] p_bus = '0;
  always @(posedge clk) begin
    if (!rst) begin
      if ((stb != cyc) || (cyc && p_cyc && p_ack) ||
          (cyc && p_cyc && !p_ack && p_bus != {adr, dato, we}))
        proto_err <= proto_err + 1;
    end
    p_cyc <= cyc;
    p_ack <= ack;
    p_bus <= {adr, dato, we};
  end

  int checks = 0;
  int errors = 0;
  logic [10:0] eq [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int base);
    chk({tag, "_count"}, 32'(wcnt - base), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      chk({tag, "_wr"}, 32'(wlog[8'(base + i)]), 32'(eq[i]));
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input string tag, input logic rw,
                         input logic [6:0] a, input logic [7:0] r,
                         input logic [7:0] d, input bit poke,
                         output logic [1:0] e, output logic [7:0] rd,
                         output int base);
    wait_ready(tag);
    base = wcnt;
    cmd_valid = 1'b1;
    cmd_rw = rw; cmd_addr = a; cmd_reg = r; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw = ~rw; cmd_addr = 7'h7f; cmd_reg = 8'hee; cmd_wdata = 8'h3c;
    chk({tag, "_busy"}, 32'({busy, cmd_ready}), 32'b10);
    if (poke) begin
      repeat (4) @(negedge clk);
      cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
    end
    for (int i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
    chk({tag, "_rsp"}, 32'(rsp_valid), 32'd1);
    e = rsp_err;
    rd = rsp_rdata;
    @(negedge clk);
    chk({tag, "_idle"}, 32'({busy, cmd_ready, rsp_valid}), 32'b010);
  endtask

  initial begin
    logic [1:0] e;
    logic [7:0] rd;
    int base, rc;

    #12;
    chk("reset_out",
        32'({busy, cmd_ready, cyc, stb, we, rsp_valid, rsp_err, rsp_rdata}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00}));
    chk("reset_bus", 32'({adr, dato}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("init");
    eq = '{11'h004, 11'h100, 11'h280};
    chk_log("init", 0);
    chk("init_busy", 32'(busy), 32'd0);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle", 32'({cmd_ready, cyc}), 32'b10);
    chk("spur_log", 32'(wcnt), 32'd3);

    run_cmd("wr1", 1'b0, 7'h02, 8'h01, 8'hA5, 1'b1, e, rd, base);
    chk("wr1_err", 32'(e), 32'd0);
    chk("wr1_rdata", 32'(rd), 32'h00);
    eq = '{11'h304, 11'h490, 11'h301, 11'h410, 11'h3A5, 11'h450};
    chk_log("wr1", base);
    chk("wr1_mem", 32'(mem[1]), 32'hA5);

    run_cmd("rd1", 1'b1, 7'h02, 8'h01, 8'h00, 1'b0, e, rd, base);
    chk("rd1_err", 32'(e), 32'd0);
    chk("rd1_rdata", 32'(rd), 32'hA5);
    eq = '{11'h304, 11'h490, 11'h301, 11'h410,
           11'h305, 11'h490, 11'h468};
    chk_log("rd1", base);
    repeat (5) @(negedge clk);
    chk("rd1_hold", 32'(rsp_rdata), 32'hA5);

    run_cmd("wr2", 1'b0, 7'h02, 8'h33, 8'h5C, 1'b0, e, rd, base);
    chk("wr2_err", 32'(e), 32'd0);
    run_cmd("rd2", 1'b1, 7'h02, 8'h33, 8'h00, 1'b0, e, rd, base);
    chk("rd2_resp", 32'({e, rd}), 32'({2'b00, 8'h5C}));

    run_cmd("nack", 1'b0, 7'h10, 8'h01, 8'h77, 1'b0, e, rd, base);
    chk("nack_resp", 32'({e, rd}), 32'({2'b01, 8'h00}));
    eq = '{11'h320, 11'h490, 11'h440};
    chk_log("nack", base);

    force_al = 1'b1;
    run_cmd("al", 1'b0, 7'h02, 8'h05, 8'h11, 1'b0, e, rd, base);
    force_al = 1'b0;
    chk("al_resp", 32'({e, rd}), 32'({2'b10, 8'h00}));
    eq = '{11'h304, 11'h490};
    chk_log("al", base);

`ifdef I2C_XFER_TIMEOUT_EN
    force_tip = 1'b1;
    run_cmd("to", 1'b0, 7'h02, 8'h02, 8'h22, 1'b0, e, rd, base);
    force_tip = 1'b0;
    chk("to_resp", 32'({e, rd}), 32'({2'b11, 8'h00}));
    eq = '{11'h304, 11'h490, 11'h440};
    chk_log("to", base);
`endif

    wait_ready("arst");
    base = wcnt;
    rc = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_rw = 1'b1; cmd_addr = 7'h02; cmd_reg = 8'h01;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 500 && (wcnt - base) < 4; i++) @(negedge clk);
    chk("arst_reach", 32'(wcnt - base), 32'd4);
    for (int i = 0; i < 100 && !(cyc && !we && adr == 3'd4); i++)
      @(negedge clk);
    chk("arst_poll", 32'({cyc, we, adr}), 32'({1'b1, 1'b0, 3'd4}));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bus", 32'({cyc, stb, busy}), 32'b001);
    @(negedge clk);
    rst = 1'b0;
    base = wcnt;
    wait_ready("reinit");
    eq = '{11'h004, 11'h100, 11'h280};
    chk_log("reinit", base);
    chk("arst_norsp", 32'(rsp_cnt - rc), 32'd0);

    run_cmd("rd3", 1'b1, 7'h02, 8'h01, 8'h00, 1'b0, e, rd, base);
    chk("rd3_resp", 32'({e, rd}), 32'({2'b00, 8'hA5}));
    chk("protocol", 32'(proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
